// File: rtl/pipe_rr_issue_scheduler.sv
// Round-robin issue scheduler sharing one fixed-latency, non-stallable pipe
// among n_req requesters. A requester-ID tag line runs alongside the pipe so
// each result is routed back to the requester that issued it. The scheduler
// caps in-flight ops and flags any result/tag misalignment as a sticky error.

// Per-requester response valid: one registered bit per lane, set when the
// retiring tag carries this lane's ID.
module pipe_rr_issue_lane #(
  parameter int ID_W = 2,
  parameter int LANE = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ret,
  input  logic [ID_W-1:0] ret_id,
  output logic            rsp_vld
);

  // Response valid is a single-cycle pulse for the matching lane.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rsp_vld <= 1'b0;
    else      rsp_vld <= ret && (ret_id == ID_W'(LANE));
  end

endmodule

module pipe_rr_issue_scheduler #(
  parameter  int width        = 8,
  parameter  int n_req        = 4,
  parameter  int latency      = 4,
  parameter  int max_inflight = 4,
  localparam int ID_W         = $clog2(n_req),
  localparam int INF_W        = $clog2(max_inflight + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [n_req-1:0]       req_vld,
  input  logic [n_req*width-1:0] req_data,
  output logic [n_req-1:0]       req_rdy,
  output logic                   pipe_vld,
  output logic [width-1:0]       pipe_data,
  input  logic                   pipe_res_vld,
  input  logic [width-1:0]       pipe_res_data,
  output logic [n_req-1:0]       rsp_vld,
  output logic [width-1:0]       rsp_data,
  output logic [INF_W-1:0]       inflight,
  output logic                   err
);

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } gnt_t;

  gnt_t                        gnt;
  logic [ID_W-1:0]             ptr;
  logic [latency:0]            vld_pipe;
  logic [latency:0][ID_W-1:0]  id_pipe;
  logic [n_req-1:0][width-1:0] req_data_a;
  logic                        full;
  logic                        ret;
  logic                        skew;

  assign req_data_a = req_data;
  assign full       = (inflight == INF_W'(max_inflight));

  // Tag output stage lines up with the pipe's result; both must agree.
  assign ret  = pipe_res_vld & vld_pipe[latency];
  assign skew = pipe_res_vld ^ vld_pipe[latency];

  // Rotating-priority search starting at ptr; suppressed while in reset or
  // while the in-flight budget is exhausted.
  always_comb begin
    gnt     = '0;
    req_rdy = '0;
    for (int k = 0; k < n_req; k++) begin
      int idx;
      idx = (int'(ptr) + k) % n_req;
      if (!gnt.vld && req_vld[idx]) begin
        gnt.vld = 1'b1;
        gnt.id  = ID_W'(idx);
      end
    end
    if (!rst || full) gnt = '0;
    if (gnt.vld) req_rdy[gnt.id] = 1'b1;
  end

  // Issue register: data holds when idle so the pipe input only toggles on use.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_vld  <= 1'b0;
      pipe_data <= '0;
      ptr       <= '0;
    end else begin
      pipe_vld <= gnt.vld;
      if (gnt.vld) begin
        pipe_data <= req_data_a[gnt.id];
        ptr       <= (int'(gnt.id) == n_req - 1) ? '0 : gnt.id + 1'b1;
      end
    end
  end

  // Tag line: stage 0 loads alongside pipe_vld, shifts every cycle since the
  // pipe never stalls; stage `latency` coincides with pipe_res_vld.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe[0] <= gnt.vld;
      id_pipe[0]  <= gnt.id;
      for (int s = 1; s <= latency; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        id_pipe[s]  <= id_pipe[s-1];
      end
    end
  end

  // In-flight count: issue adds, tag retirement removes, both cancel out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) inflight <= '0;
    else if (gnt.vld && !vld_pipe[latency]) inflight <= inflight + 1'b1;
    else if (!gnt.vld && vld_pipe[latency]) inflight <= inflight - 1'b1;
  end

  // Shared response data captured only on a properly tagged result; a skewed
  // result is dropped and latches the sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_data <= '0;
      err      <= 1'b0;
    end else begin
      if (ret)  rsp_data <= pipe_res_data;
      if (skew) err      <= 1'b1;
    end
  end

  for (genvar i = 0; i < n_req; i++) begin : g_lane
    pipe_rr_issue_lane #(
      .ID_W (ID_W),
      .LANE (i)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .ret     (ret),
      .ret_id  (id_pipe[latency]),
      .rsp_vld (rsp_vld[i])
    );
  end

endmodule

// File: tb/tb_pipe_rr_issue_scheduler.sv
// Scoreboard bench: a behavioural model predicts grants, in-flight count, error
// and responses; a separate monitor pops expected responses as they appear.
module tb_pipe_rr_issue_scheduler;

  localparam int W = 8;
  localparam int N = 4;
  localparam int L = 4;
  localparam int M = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] req_vld;
  logic [N*W-1:0] req_data;
  logic [N-1:0] req_rdy;
  logic         pipe_vld;
  logic [W-1:0] pipe_data;
  logic         pipe_res_vld;
  logic [W-1:0] pipe_res_data;
  logic [N-1:0] rsp_vld;
  logic [W-1:0] rsp_data;
  logic [2:0]   inflight;
  logic         err;

  pipe_rr_issue_scheduler #(
    .width (W), .n_req (N), .latency (L), .max_inflight (M)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_vld       (req_vld),
    .req_data      (req_data),
    .req_rdy       (req_rdy),
    .pipe_vld      (pipe_vld),
    .pipe_data     (pipe_data),
    .pipe_res_vld  (pipe_res_vld),
    .pipe_res_data (pipe_res_data),
    .rsp_vld       (rsp_vld),
    .rsp_data      (rsp_data),
    .inflight      (inflight),
    .err           (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int         id;
    logic [W-1:0] d;
    int         c;
  } sb_t;

  sb_t  sb[$];
  int   gq[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   mcyc = 0;
  int   ptr = 0;
  logic err_exp = 1'b0;
  logic prev_g = 1'b0;
  logic [W-1:0] prev_d = '0;
  logic inject = 1'b0;
  logic clear_pipe = 1'b1;
  logic         hv [0:L];
  logic [W-1:0] hd [0:L];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp, input int c);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, c, act, exp);
    end
  endtask

  initial begin
    for (int k = 0; k <= L; k++) begin hv[k] = 1'b0; hd[k] = '0; end
    pipe_res_vld  = 1'b0;
    pipe_res_data = '0;
  end

  // Pipe stand-in (identity, L cycles) followed by the reference model.
  always @(negedge clk) begin
    int exp_inf;
    int gid;
    logic gv;
    logic tagv;
    logic [N-1:0] exp_rdy;
    for (int k = L; k > 0; k--) begin hv[k] = hv[k-1]; hd[k] = hd[k-1]; end
    hv[0] = pipe_vld;
    hd[0] = pipe_data;
    if (!rst && clear_pipe)
      for (int k = 0; k <= L; k++) hv[k] = 1'b0;
    pipe_res_vld  = hv[L] | inject;
    pipe_res_data = hd[L];

    if (!rst) begin
      chk("rst_req_rdy", 32'(req_rdy), 0, cyc);
      chk("rst_pipe_vld", 32'(pipe_vld), 0, cyc);
      chk("rst_inflight", 32'(inflight), 0, cyc);
      chk("rst_err", 32'(err), 0, cyc);
      gq.delete();
      sb.delete();
      ptr = 0;
      err_exp = 1'b0;
      prev_g = 1'b0;
    end else begin
      // ops issued within the last L+1 cycles are still in flight
      exp_inf = 0;
      foreach (gq[j]) if (gq[j] >= cyc - L - 1) exp_inf++;
      chk("inflight", 32'(inflight), exp_inf, cyc);
      chk("err", 32'(err), 32'(err_exp), cyc);
      chk("pipe_vld", 32'(pipe_vld), 32'(prev_g), cyc);
      if (prev_g) chk("pipe_data", 32'(pipe_data), 32'(prev_d), cyc);

      gv = 1'b0;
      gid = 0;
      if (exp_inf < M)
        for (int k = 0; k < N; k++)
          if (!gv && req_vld[(ptr + k) % N]) begin gv = 1'b1; gid = (ptr + k) % N; end
      exp_rdy = '0;
      if (gv) exp_rdy[gid] = 1'b1;
      chk("req_rdy", 32'(req_rdy), 32'(exp_rdy), cyc);

      tagv = 1'b0;
      foreach (gq[j]) if (gq[j] == cyc - L - 1) tagv = 1'b1;
      if (pipe_res_vld != tagv) err_exp = 1'b1;

      prev_g = gv;
      if (gv) begin
        prev_d = req_data[gid*W +: W];
        gq.push_back(cyc);
        sb.push_back('{gid, prev_d, cyc + L + 2});
        ptr = (gid + 1) % N;
      end
      while (gq.size() > 0 && gq[0] < cyc - L - 1) void'(gq.pop_front());
    end
    cyc++;
  end

  // Monitor: every response must match the oldest outstanding issue.
  always @(negedge clk) begin
    sb_t e;
    logic [N-1:0] ev;
    if (!rst) begin
      chk("rst_rsp_vld", 32'(rsp_vld), 0, mcyc);
    end else begin
      while (sb.size() > 0 && sb[0].c < mcyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL rsp_missing cyc=%0d got=none exp=id%0d", mcyc, sb[0].id);
        void'(sb.pop_front());
      end
      if (rsp_vld != '0) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rsp_unexpected cyc=%0d got=%0h exp=none", mcyc, rsp_vld);
        end else begin
          e = sb.pop_front();
          ev = '0;
          ev[e.id] = 1'b1;
          chk("rsp_vld", 32'(rsp_vld), 32'(ev), mcyc);
          chk("rsp_data", 32'(rsp_data), 32'(e.d), mcyc);
          chk("rsp_cycle", mcyc, e.c, mcyc);
        end
      end
    end
    mcyc++;
  end

  task automatic step(input logic [N-1:0] v, input int n);
    repeat (n) begin
      @(posedge clk); #1;
      req_vld  = v;
      req_data = $urandom;
    end
  endtask

  initial begin
    rst = 1'b0;
    req_vld = '0;
    req_data = '0;
    step(4'hF, 3);
    @(posedge clk); #1 rst = 1'b1;

    step(4'hF, 30);          // round robin under full load, budget limited
    step(4'b1010, 30);       // only 1 and 3 may win
    repeat (200) step(N'($urandom), 1);
    step(4'h0, L + 4);

    // Routing: two requesters in consecutive cycles
    @(posedge clk); #1 req_vld = 4'b0100; req_data = '0; req_data[2*W +: W] = 8'hA5;
    @(posedge clk); #1 req_vld = 4'b0001; req_data = '0; req_data[0 +: W] = 8'h3C;
    step(4'h0, L + 4);

    // Skew: stray result with no tag
    @(posedge clk); #1 inject = 1'b1;
    @(posedge clk); #1 inject = 1'b0;
    step(4'hF, 12);

    // Mid-flight reset with pipe flushed: err and inflight clear
    @(posedge clk); #1 rst = 1'b0;
    step(4'hF, 2);
    @(posedge clk); #1 rst = 1'b1;
    step(4'hF, 20);

    // Mid-flight reset with pipe not flushed: stray results flag err
    clear_pipe = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    step(4'h0, 2);
    @(posedge clk); #1 rst = 1'b1;
    repeat (60) step(N'($urandom), 1);
    step(4'h0, L + 6);

    @(negedge clk); #1;
    chk("sb_drained", sb.size(), 0, cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
